// File: rtl/ram_sp_param_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package ram_pkg;

    // Clear sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Write-through mode selectors for the WR_THROUGH parameter.
    localparam int WT_OFF = 0;
    localparam int WT_ON  = 1;

    // Number of byte lanes in a data word.
    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sp_param_if.sv
// Request/response bus of the single-port RAM.
interface ram_sp_param_if
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int LANES = lane_count(DATA_W);

    logic              ena;
    logic              wena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  byte_en;
    logic              clr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;

    modport master (
        output ena, wena, addr, wdata, byte_en, clr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  ena, wena, addr, wdata, byte_en, clr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/ram_sp_param_clr_ctrl.sv
// Clear sequencer: sweeps INIT_VAL over the whole array after reset or on clr.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    // Sequencer FSM; clr is only honoured in IDLE, so a sweep is never restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, registered
// read, optional write-through response and a built-in clear sequencer.
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0,
    parameter int                WR_THROUGH = WT_OFF
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_sp_param_if.slave  bus
);
    localparam int              LANES   = lane_count(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;
    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged;

    // Replace only the enabled byte lanes of the stored word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  lanes
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    ram_clr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    assign bus.busy = busy;

    // Requests are ignored while the sweep owns the array; out-of-range
    // addresses read as zero and never touch the array.
    assign accept   = bus.ena && !busy;
    assign in_range = ({1'b0, bus.addr} < DEPTH_X);
    assign cur_word = in_range ? mem[bus.addr] : '0;
    assign merged   = in_range ? merge_bytes(cur_word, bus.wdata, bus.byte_en) : '0;

    // Array write port: the sweep and user writes never coincide because busy gates requests.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (accept && bus.wena && in_range) begin
            mem[bus.addr] <= merged;
        end
    end

    // Response register: rvalid is a one-cycle strobe, rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= 1'b0;
            if (accept) begin
                if (!bus.wena) begin
                    bus.rdata  <= cur_word;
                    bus.rvalid <= 1'b1;
                end else if (WR_THROUGH == WT_ON) begin
                    bus.rdata  <= merged;
                    bus.rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM; next generation of the team's 32x32 bidirectional-bus RAM.
- Separate write/read data buses replace the tri-state bus. Adds:
  - byte-lane write enables
  - a registered read with a valid strobe
  - a selectable write-through mode
  - a hardware clear sequencer that initialises the whole array after reset or on command
- Sits behind the CPU/datapath memory interface as data or instruction store.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; need not be a power of two.
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= DEPTH.
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.
- WR_THROUGH, 0:
  - 0 = write produces no read response.
  - 1 = write returns the merged new word on rdata with rvalid.

Ports:
- clk  in  1  memory clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  request valid; a request is accepted only when ena=1 and busy=0.
- wena  in  1  1 = write, 0 = read; meaningful only with ena.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write enable; bit i covers wdata[8i+7:8i].
- clr  in  1  single-cycle request to start a full-array clear.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle strobe qualifying rdata.
- busy  out  1  clear sequencer active; requests are ignored.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rdata=0, rvalid=0, busy=1.
  - FSM enters CLEAR; clear counter set to 0.
  - The array itself is not reset asynchronously.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes INIT_VAL (all bytes) to mem[cnt], then cnt++. When cnt=DEPTH-1 is written, go to IDLE next edge.
  - A clear therefore takes exactly DEPTH cycles. busy=1 throughout CLEAR and is 0 in IDLE (busy is a registered output).
  - IDLE: clr=1 goes to CLEAR with cnt=0. clr is sampled only in IDLE; clr during CLEAR is ignored, with no restart.
- Simultaneous clr and request in IDLE: the request is executed this cycle; CLEAR starts next cycle.
- Reset mid-clear restarts the sweep from 0.
- Read (accepted, wena=0):
  - rdata <= mem[addr] and rvalid <= 1 at the next rising edge; latency 1.
  - byte_en is ignored on reads.
- Write (accepted, wena=1):
  - For each i with byte_en[i]=1, the corresponding mem[addr] byte takes wdata byte i; other bytes are unchanged.
  - byte_en all-zero is a legal no-op write.
  - WR_THROUGH=0: rvalid=0 next cycle; rdata holds its previous value.
  - WR_THROUGH=1: rdata <= merged new word and rvalid=1 next cycle.
- No accepted request (ena=0 or busy=1): rvalid=0 next cycle; rdata holds its last value. rdata is never high-Z.
- rvalid is high for exactly one cycle per response. Back-to-back reads give one response per cycle.
- Out of range (addr >= DEPTH):
  - Writes are dropped.
  - Reads return all-zero with rvalid=1.
  - Out-of-range requests are not flagged as errors.
- Width rule: byte merge uses DATA_W/8 lanes; no partial-byte lanes.

Decomposition:
- Package ram_pkg:
  - FSM state enum (ST_IDLE, ST_CLEAR)
  - WR_THROUGH mode constants (WT_OFF=0, WT_ON=1)
  - function computing the lane count from DATA_W
- Sub-module ram_clr_ctrl:
  - owns the FSM, clear counter and busy
  - outputs clear write enable and clear address to the top, which muxes them over the user port
- Array and read register stay in ram_sp_param.

Test Plan:
- Reset then idle, defaults: release rst_n → busy=1 for exactly 32 cycles, then 0. Reading addr 0..31 returns INIT_VAL=0, each with rvalid=1 one cycle after the request.
- Full write, then byte-lane write: write 0xDEADBEEF to addr 5 with byte_en=4'hF, then write wdata 0x11223344 with byte_en=4'b0101 → a read of addr 5 returns 0xDE22BE44.
- Request during busy: ena=1, wena=1, addr 3, data 0xA5A5A5A5 while busy=1 → after clear, addr 3 reads 0; rvalid never asserted during busy.
- clr plus same-cycle write: in IDLE, pulse clr together with write 0x12345678 to addr 7 → busy rises the next cycle for 32 cycles; addr 7 afterwards reads INIT_VAL.
- WR_THROUGH=1, DEPTH=20, ADDR_W=5, DATA_W=64:
  - Write 0x0123456789ABCDEF with all bytes enabled → rdata=0x0123456789ABCDEF with rvalid=1 next cycle.
  - Read addr 25 → rdata=0, rvalid=1.
  - Write addr 25, then read addr 25 → still 0.
- Reset mid-clear: assert rst_n=0 at clear cycle 10 for 2 cycles → after release busy=1 for a full DEPTH cycles; rdata=0 and rvalid=0 during reset.
